// File: rtl/crop_pkg.sv
// crop_pkg: definitions shared by the crop/pool pixel pipeline.
//   PIX_W      - default pixel width (signed two's complement)
//   HSUM_GROW  - extra bits for a 2-pixel horizontal sum
//   VSUM_GROW  - extra bits for a 4-pixel window sum
//   pixel_t    - default-width signed pixel
//   hsum_w/vsum_w - sum widths for a given pixel width
package crop_pkg;
  localparam int PIX_W     = 12;
  localparam int HSUM_GROW = 1;
  localparam int VSUM_GROW = 2;

  typedef logic signed [PIX_W-1:0] pixel_t;

  function automatic int hsum_w(input int pw);
    return pw + HSUM_GROW;
  endfunction

  function automatic int vsum_w(input int pw);
    return pw + VSUM_GROW;
  endfunction
endpackage

// File: rtl/pool_line_buffer.sv
// pool_line_buffer: one-row store of horizontal pair sums for the 2x2 pooler.
//   clk     - write clock
//   wr_en   - write wr_data to entry wr_addr on the rising edge
//   wr_addr - write index (column pair)
//   wr_data - horizontal sum from the even row
//   rd_addr - read index (column pair)
//   rd_data - combinational read of entry rd_addr
// No reset: every entry is rewritten on an even row before it is read.
module pool_line_buffer #(
  parameter int DEPTH = 10,
  parameter int WIDTH = 13,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/pool2x2_filter.sv
// pool2x2_filter: non-overlapping 2x2 average pooling of a raster pixel stream.
//   clk       - clock, rising edge
//   reset     - asynchronous active-high reset
//   pixel_in  - signed raster-order input pixel
//   in_valid  - pixel_in valid
//   in_ready  - block accepts pixel_in this cycle
//   pixel_out - floor average of one 2x2 window (registered)
//   out_valid - pixel_out valid
//   out_ready - downstream accepts pixel_out
// Even rows park the horizontal pair sum in a line buffer; the odd row adds its
// own pair to it, so each output appears one cycle after its last pixel.
module pool2x2_filter
  import crop_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = PIX_W,
  parameter int IN_ROWS         = 20,
  parameter int IN_COLS         = 20
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [PIXEL_BIT_WIDTH-1:0] pixel_out,
  output logic                       out_valid,
  input  logic                       out_ready
);
  localparam int HW    = hsum_w(PIXEL_BIT_WIDTH);
  localparam int VW    = vsum_w(PIXEL_BIT_WIDTH);
  localparam int RW    = $clog2(IN_ROWS);
  localparam int CW    = $clog2(IN_COLS);
  localparam int DEPTH = IN_COLS / 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [RW-1:0]                     row;
  logic [CW-1:0]                     col;
  logic signed [PIXEL_BIT_WIDTH-1:0] held;
  logic signed [PIXEL_BIT_WIDTH-1:0] pix_s;
  logic signed [HW-1:0]              h_sum;
  logic signed [HW-1:0]              lb_rd_s;
  logic [HW-1:0]                     lb_rd;
  logic signed [VW-1:0]              v_sum;
  logic [AW-1:0]                     lb_addr;
  logic                              accept, last_col, last_row;
  logic                              lb_wr, win_done;

  // Output register can take a new value whenever it is empty or draining.
  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign last_col = (col == CW'(IN_COLS - 1));
  assign last_row = (row == RW'(IN_ROWS - 1));

  assign pix_s    = pixel_in;
  assign h_sum    = HW'(held) + HW'(pix_s);
  assign lb_rd_s  = lb_rd;
  assign v_sum    = VW'(lb_rd_s) + VW'(held) + VW'(pix_s);
  assign lb_addr  = AW'(col >> 1);

  assign lb_wr    = accept & ~row[0] & col[0];
  assign win_done = accept &  row[0] & col[0];

  pool_line_buffer #(.DEPTH(DEPTH), .WIDTH(HW), .AW(AW)) u_lb (
    .clk     (clk),
    .wr_en   (lb_wr),
    .wr_addr (lb_addr),
    .wr_data (h_sum),
    .rd_addr (lb_addr),
    .rd_data (lb_rd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row  <= '0;
      col  <= '0;
      held <= '0;
    end else if (accept) begin
      if (!col[0]) held <= pix_s;
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Arithmetic shift floors toward minus infinity; the 4-pixel mean always
  // fits back into the pixel width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      pixel_out <= '0;
    end else if (win_done) begin
      out_valid <= 1'b1;
      pixel_out <= PIXEL_BIT_WIDTH'(v_sum >>> 2);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
